// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares the configuration SPI flash between the
// bootloader SPI master (requester 0) and the user SPI master (requester 1).
// The granted requester's CS/SCK/MOSI are muxed onto the flash pins, a
// minimum CS-high gap separates owners, and boot_pending freezes new grants.
// Optional ownership watchdog: define ARBITER_TIMEOUT_EN.
module spi_flash_arbiter #(
  parameter int unsigned CS_GAP_CYCLES  = 4,
  parameter int unsigned ROUND_ROBIN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] spi_cs_i,
  input  logic [1:0] spi_sck_i,
  input  logic [1:0] spi_mosi_i,
  output logic       spi_miso_o,
  input  logic       boot_pending,
  output logic       flash_csn,
  output logic       flash_sck,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic       busy,
  output logic       abort
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] gap_cnt, gap_cnt_nx;
  logic       rr_ptr, rr_ptr_nx;
  logic [1:0] gnt_nx;
  logic       abort_nx;
  logic       owning;
  logic       own_idx;
  logic       winner;
  logic [1:0] req_eff;
  logic       timeout_hit;

  assign owning = (state == OWN0) || (state == OWN1);
  assign own_idx = (state == OWN1);

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] to_cnt;
  logic [1:0]  cs_q, sck_q;
  logic [1:0]  blocked;
  logic        activity;

  assign activity = (spi_cs_i[own_idx] != cs_q[own_idx]) ||
                    (spi_sck_i[own_idx] != sck_q[own_idx]);
  // The revoke fires on the last static cycle, so a silent owner holds the
  // bus for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = owning && !activity && (to_cnt == TIMEOUT_LAST);
  assign req_eff = req & ~blocked;

  // Watchdog counter, previous-cycle pin history and revoked-requester lockout.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      to_cnt  <= '0;
      cs_q    <= '1;
      sck_q   <= '0;
      blocked <= '0;
    end else begin
      cs_q  <= spi_cs_i;
      sck_q <= spi_sck_i;
      if (!owning || activity || timeout_hit) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 24'd1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (!req[i]) blocked[i] <= 1'b0;
      end
      if (timeout_hit && req[own_idx]) blocked[own_idx] <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^24'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
  assign req_eff = req;
`endif

  // State, grant, gap counter, round-robin pointer and abort registers.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gap_cnt <= '0;
      rr_ptr  <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      gap_cnt <= gap_cnt_nx;
      rr_ptr  <= rr_ptr_nx;
      abort   <= abort_nx;
    end
  end

  // Next-state logic: arbitration in IDLE, release detection in OWNx, gap countdown.
  always_comb begin
    state_nx   = state;
    gnt_nx     = '0;
    gap_cnt_nx = gap_cnt;
    rr_ptr_nx  = rr_ptr;
    abort_nx   = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: begin
        if (!boot_pending && (req_eff != 2'b00)) begin
          if (req_eff == 2'b11) winner = (ROUND_ROBIN != 0) ? rr_ptr : 1'b0;
          else                  winner = req_eff[1];
          state_nx = winner ? OWN1 : OWN0;
          gnt_nx   = winner ? 2'b10 : 2'b01;
          if (ROUND_ROBIN != 0) rr_ptr_nx = ~winner;
        end
      end
      OWN0, OWN1: begin
        if (!req[own_idx] || timeout_hit) begin
          state_nx   = GAP;
          gap_cnt_nx = GAP_LOAD;
          abort_nx   = !spi_cs_i[own_idx];
        end else begin
          gnt_nx = own_idx ? 2'b10 : 2'b01;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_nx = IDLE;
        else                 gap_cnt_nx = gap_cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Flash pin mux from the registered owner; idle levels otherwise.
  always_comb begin
    flash_csn  = 1'b1;
    flash_sck  = 1'b0;
    flash_mosi = 1'b0;
    if (owning) begin
      flash_csn  = spi_cs_i[own_idx];
      flash_sck  = spi_sck_i[own_idx];
      flash_mosi = spi_mosi_i[own_idx];
    end
  end

  assign busy       = (state != IDLE);
  assign spi_miso_o = flash_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed testbench for spi_flash_arbiter: a fixed-priority instance and a
// round-robin instance share all inputs; each task checks one scenario.
module tb_spi_flash_arbiter;

  logic       clk_usb = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] spi_cs_i, spi_sck_i, spi_mosi_i;
  logic       boot_pending;
  logic       flash_miso;

  logic [1:0] gnt_f, gnt_r;
  logic       miso_f, miso_r;
  logic       csn_f, csn_r, sck_f, sck_r, mosi_f, mosi_r;
  logic       busy_f, busy_r, abort_f, abort_r;

  int checks = 0;
  int errors = 0;

  always #5 clk_usb = ~clk_usb;

  spi_flash_arbiter #(.CS_GAP_CYCLES(4), .ROUND_ROBIN(0)) dut_fp (
    .clk_usb(clk_usb), .reset(reset), .req(req), .gnt(gnt_f),
    .spi_cs_i(spi_cs_i), .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(miso_f), .boot_pending(boot_pending),
    .flash_csn(csn_f), .flash_sck(sck_f), .flash_mosi(mosi_f),
    .flash_miso(flash_miso), .busy(busy_f), .abort(abort_f)
  );

  spi_flash_arbiter #(.CS_GAP_CYCLES(4), .ROUND_ROBIN(1)) dut_rr (
    .clk_usb(clk_usb), .reset(reset), .req(req), .gnt(gnt_r),
    .spi_cs_i(spi_cs_i), .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(miso_r), .boot_pending(boot_pending),
    .flash_csn(csn_r), .flash_sck(sck_r), .flash_mosi(mosi_r),
    .flash_miso(flash_miso), .busy(busy_r), .abort(abort_r)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_usb);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; spi_cs_i = 2'b11; spi_sck_i = 2'b00;
    spi_mosi_i = 2'b00; boot_pending = 1'b0; flash_miso = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt_f !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_f); end
    checks++; if (csn_f !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", csn_f); end
    checks++; if ({sck_f, mosi_f} !== 2'b00) begin errors++; $display("FAIL reset_sck_mosi: got %b expected 00", {sck_f, mosi_f}); end
    checks++; if ({busy_f, abort_f} !== 2'b00) begin errors++; $display("FAIL reset_busy_abort: got %b expected 00", {busy_f, abort_f}); end
    checks++; if (gnt_r !== 2'b00) begin errors++; $display("FAIL reset_gnt_rr: got %b expected 00", gnt_r); end
    flash_miso = 1'b1; #1;
    checks++; if (miso_f !== 1'b1) begin errors++; $display("FAIL miso_high: got %b expected 1", miso_f); end
    flash_miso = 1'b0; #1;
    checks++; if (miso_f !== 1'b0) begin errors++; $display("FAIL miso_low: got %b expected 0", miso_f); end
  endtask

  task automatic test_single_grant();
    do_reset();
    step(1);
    req = 2'b01;
    #1;
    checks++; if (gnt_f !== 2'b00) begin errors++; $display("FAIL grant_early: got %b expected 00", gnt_f); end
    step(1);
    checks++; if (gnt_f !== 2'b01) begin errors++; $display("FAIL grant_latency: got %b expected 01", gnt_f); end
    checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL own_busy: got %b expected 1", busy_f); end
    spi_cs_i = 2'b10; #1;
    checks++; if (csn_f !== 1'b0) begin errors++; $display("FAIL csn_follow_low: got %b expected 0", csn_f); end
    spi_sck_i = 2'b01; spi_mosi_i = 2'b01; #1;
    checks++; if ({sck_f, mosi_f} !== 2'b11) begin errors++; $display("FAIL sck_mosi_follow: got %b expected 11", {sck_f, mosi_f}); end
    spi_cs_i = 2'b01; spi_sck_i = 2'b10; spi_mosi_i = 2'b10; #1;
    checks++; if ({csn_f, sck_f, mosi_f} !== 3'b100) begin errors++; $display("FAIL non_owner_ignored: got %b expected 100", {csn_f, sck_f, mosi_f}); end
    spi_cs_i = 2'b11; spi_sck_i = 2'b00; spi_mosi_i = 2'b00;
    step(1);
    req = 2'b00;
    step(1);
    checks++; if ({gnt_f, busy_f, abort_f} !== 4'b0010) begin errors++; $display("FAIL release_clean: got gnt/busy/abort %b expected 0010", {gnt_f, busy_f, abort_f}); end
    step(3);
    checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b expected 1", busy_f); end
    step(1);
    checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL gap_end_idle: got %b expected 0", busy_f); end
  endtask

  task automatic test_fixed_priority_gap();
    do_reset();
    req = 2'b11;
    step(1);
    checks++; if (gnt_f !== 2'b01) begin errors++; $display("FAIL fixed_priority: got %b expected 01", gnt_f); end
    step(2);
    req = 2'b10;
    step(1);
    checks++; if (gnt_f !== 2'b00) begin errors++; $display("FAIL gap_gnt_fall: got %b expected 00", gnt_f); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if ({gnt_f, csn_f} !== 3'b001) begin errors++; $display("FAIL gap_hold_%0d: got gnt/csn %b expected 001", k, {gnt_f, csn_f}); end
    end
    step(1);
    checks++; if (gnt_f !== 2'b10) begin errors++; $display("FAIL gap_regrant: got %b expected 10", gnt_f); end
    req = 2'b00;
    step(6);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    logic [1:0] owner;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    do_reset();
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 20 && gnt_r == 2'b00; c++) step(1);
      owner = gnt_r;
      checks++; if (owner !== exp_seq[g]) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", g, owner, exp_seq[g]); end
      step(7);
      req = ~owner;
      step(1);
      req = 2'b11;
    end
    req = 2'b00;
    step(8);
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b01;
    step(1);
    spi_cs_i = 2'b10;
    step(2);
    checks++; if ({gnt_f, csn_f} !== 3'b010) begin errors++; $display("FAIL abort_setup: got gnt/csn %b expected 010", {gnt_f, csn_f}); end
    req = 2'b00;
    step(1);
    checks++; if ({abort_f, gnt_f, csn_f} !== 4'b1001) begin errors++; $display("FAIL abort_pulse: got abort/gnt/csn %b expected 1001", {abort_f, gnt_f, csn_f}); end
    step(1);
    checks++; if (abort_f !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b expected 0", abort_f); end
    spi_cs_i = 2'b11;
    step(6);
  endtask

  task automatic test_boot_pending();
    do_reset();
    req = 2'b10;
    step(1);
    boot_pending = 1'b1;
    step(3);
    checks++; if (gnt_f !== 2'b10) begin errors++; $display("FAIL boot_keeps_owner: got %b expected 10", gnt_f); end
    req = 2'b01;
    step(1);
    checks++; if (gnt_f !== 2'b00) begin errors++; $display("FAIL boot_release: got %b expected 00", gnt_f); end
    step(10);
    checks++; if ({gnt_f, busy_f} !== 3'b000) begin errors++; $display("FAIL boot_freeze: got gnt/busy %b expected 000", {gnt_f, busy_f}); end
    boot_pending = 1'b0;
    step(1);
    checks++; if (gnt_f !== 2'b01) begin errors++; $display("FAIL boot_clear_grant: got %b expected 01", gnt_f); end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    req = 2'b01; spi_cs_i = 2'b10;
    step(2);
    reset = 1'b1;
    step(1);
    checks++; if ({gnt_f, csn_f, abort_f, busy_f} !== 5'b00100) begin errors++; $display("FAIL mid_reset: got gnt/csn/abort/busy %b expected 00100", {gnt_f, csn_f, abort_f, busy_f}); end
    reset = 1'b0;
    step(1);
    checks++; if ({gnt_f, abort_f} !== 3'b010) begin errors++; $display("FAIL post_reset_regrant: got gnt/abort %b expected 010", {gnt_f, abort_f}); end
    req = 2'b00; spi_cs_i = 2'b11;
    step(6);
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fixed_priority_gap();
    test_round_robin();
    test_abort();
    test_boot_pending();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
